// File: rtl/pwm_decode_if.sv
// PWM decoder bundle: two raw PWM lines in, decoded duty/period/status out.
// The master drives the PWM lines; the slave is the decoder.
interface pwm_decode_if #(
  parameter int CNT_W = 10
);
  logic             pulseH;
  logic             pulseG;
  logic [CNT_W-1:0] vq;
  logic [11:0]      period;
  logic             dir;
  logic             valid;
  logic             stopped;
  logic             fault;

  modport master (
    output pulseH, pulseG,
    input  vq, period, dir, valid, stopped, fault
  );

  modport slave (
    input  pulseH, pulseG,
    output vq, period, dir, valid, stopped, fault
  );
endinterface

// File: rtl/pwm_decode.sv
// Decodes a forward/reverse PWM pair into duty (high clocks), period and direction,
// with a no-edge timeout and a sticky overlap fault.
module pwm_decode #(
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 2048
) (
  input logic         clk,
  input logic         rst,
  pwm_decode_if.slave bus
);

  //  state | meaning
  //  IDLE  | no period in progress; next rise starts a measurement, no valid
  //  HIGH  | combined line p high, counting high time and period
  //  LOW   | combined line p low, waiting for the rise that closes the period

  localparam int              HI_W    = CNT_W + 1;
  localparam logic [11:0]     PER_MAX = 12'hFFF;
  localparam logic [HI_W-1:0] HI_MAX  = '1;
  localparam logic [CNT_W-1:0] VQ_MAX = '1;
  localparam logic [11:0]     TO_LIM  = 12'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state;
  logic             h_meta, sh;
  logic             g_meta, sg;
  logic             p_prev;
  logic             prime_0, primed;
  logic [HI_W-1:0]  hi_cnt;
  logic [11:0]      per_cnt;
  logic [11:0]      to_cnt;
  logic             dir_cur;
  logic [CNT_W-1:0] vq;
  logic [11:0]      period;
  logic             dir;
  logic             valid;
  logic             stopped;
  logic             fault;

  logic p, rise, fall, any_edge, timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_meta  <= 1'b0;
      sh      <= 1'b0;
      g_meta  <= 1'b0;
      sg      <= 1'b0;
      p_prev  <= 1'b0;
      prime_0 <= 1'b0;
      primed  <= 1'b0;
    end else begin
      h_meta  <= bus.pulseH;
      sh      <= h_meta;
      g_meta  <= bus.pulseG;
      sg      <= g_meta;
      p_prev  <= p;
      prime_0 <= 1'b1;
      primed  <= prime_0;
    end
  end

  assign p           = sh | sg;
  assign rise        = p & ~p_prev;
  assign fall        = ~p & p_prev;
  assign any_edge    = rise | fall;
  assign timeout_hit = ~any_edge & (to_cnt == TO_LIM) & ~stopped;

  // The quiet-time count only starts once the synchronizer holds real samples,
  // so a reset release behaves like a synchronizer-delayed edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (any_edge) begin
      to_cnt <= '0;
    end else if (primed && to_cnt != TO_LIM) begin
      to_cnt <= to_cnt + 12'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      hi_cnt  <= '0;
      per_cnt <= '0;
      dir_cur <= 1'b1;
      vq      <= '0;
      period  <= '0;
      dir     <= 1'b1;
      valid   <= 1'b0;
      stopped <= 1'b0;
      fault   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (sh && sg) fault <= 1'b1;
      if (any_edge) stopped <= 1'b0;
      if (state != IDLE && per_cnt != PER_MAX) per_cnt <= per_cnt + 12'd1;
      if (state == HIGH && p && hi_cnt != HI_MAX) hi_cnt <= hi_cnt + HI_W'(1);

      if (timeout_hit) begin
        state   <= IDLE;
        stopped <= 1'b1;
        valid   <= 1'b1;
        vq      <= p ? VQ_MAX : '0;
        period  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state   <= HIGH;
              hi_cnt  <= HI_W'(1);
              per_cnt <= 12'd1;
              dir     <= sh;
              dir_cur <= sh;
            end
          end
          HIGH: begin
            if (fall) state <= LOW;
          end
          LOW: begin
            if (rise) begin
              state   <= HIGH;
              valid   <= 1'b1;
              period  <= per_cnt;
              vq      <= hi_cnt[HI_W-1] ? VQ_MAX : hi_cnt[CNT_W-1:0];
              // dir travels with the measurement it describes, one period behind the line
              dir     <= dir_cur;
              dir_cur <= sh;
              hi_cnt  <= HI_W'(1);
              per_cnt <= 12'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.vq      = vq;
  assign bus.period  = period;
  assign bus.dir     = dir;
  assign bus.valid   = valid;
  assign bus.stopped = stopped;
  assign bus.fault   = fault;

endmodule

// File: tb/tb_pwm_decode.sv
// Directed bench for pwm_decode: timestamp-based reference model checked every cycle,
// plus hand-computed expectations per scenario.
module tb_pwm_decode;
  localparam int CNT_W   = 10;
  localparam int TIMEOUT = 2048;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ph  = 1'b0;
  logic pg  = 1'b0;

  always #5 clk = ~clk;

  pwm_decode_if #(.CNT_W(CNT_W)) bus ();
  assign bus.pulseH = ph;
  assign bus.pulseG = pg;

  pwm_decode #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference model: works on edge timestamps of the synchronized combined line.
  int m_t = 0, m_ref = 2, m_start = 0, m_fall = 0;
  bit h1 = 0, h2 = 0, g1 = 0, g2 = 0, pp = 0;
  bit in_per = 0, fell = 0, dmeas = 1;
  bit s_h, s_g, s_p, s_rise, s_fall;
  int m_vq = 0, m_per = 0;
  bit m_dir = 1, m_valid = 0, m_stop = 0, m_fault = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_t = 0; m_ref = 2; h1 = 0; h2 = 0; g1 = 0; g2 = 0; pp = 0;
      in_per = 0; fell = 0; dmeas = 1;
      m_vq = 0; m_per = 0; m_dir = 1; m_valid = 0; m_stop = 0; m_fault = 0;
    end else begin
      s_h = h2; s_g = g2; s_p = s_h | s_g;
      s_rise = s_p && !pp;
      s_fall = !s_p && pp;
      m_t++;
      m_valid = 0;
      if (s_h && s_g) m_fault = 1;
      if (s_rise || s_fall) begin
        m_stop = 0;
        m_ref  = m_t;
      end
      if (s_fall && in_per && !fell) begin
        fell   = 1;
        m_fall = m_t;
      end
      if (s_rise) begin
        if (in_per) begin
          m_valid = 1;
          m_per   = imin(m_t - m_start, 4095);
          m_vq    = imin(imin(m_fall - m_start, 2047), 1023);
          m_dir   = dmeas;
        end else begin
          m_dir = s_h;
        end
        dmeas   = s_h;
        in_per  = 1;
        fell    = 0;
        m_start = m_t;
      end else if (!s_fall && (m_t - m_ref) == TIMEOUT + 1) begin
        m_valid = 1;
        m_stop  = 1;
        m_vq    = s_p ? 1023 : 0;
        m_per   = 0;
        in_per  = 0;
      end
      pp = s_p;
      h2 = h1; h1 = ph;
      g2 = g1; g1 = pg;
    end
  end

  int q_vq[$];
  int q_per[$];
  int q_dir[$];
  logic [CNT_W+15:0] act_v, exp_v;

  initial forever begin
    @(negedge clk);
    act_v = {bus.vq, bus.period, bus.dir, bus.valid, bus.stopped, bus.fault};
    exp_v = {m_vq[CNT_W-1:0], m_per[11:0], m_dir, m_valid, m_stop, m_fault};
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL outputs @%0t: got vq=%0d period=%0d dir=%b valid=%b stopped=%b fault=%b, expected vq=%0d period=%0d dir=%b valid=%b stopped=%b fault=%b",
               $time, bus.vq, bus.period, bus.dir, bus.valid, bus.stopped, bus.fault,
               m_vq, m_per, m_dir, m_valid, m_stop, m_fault);
    end
    if (bus.valid === 1'b1) begin
      q_vq.push_back(int'(bus.vq));
      q_per.push_back(int'(bus.period));
      q_dir.push_back(int'(bus.dir));
    end
  end

  task automatic hold(input bit h, input bit g, input int n);
    ph = h;
    pg = g;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input bit h, input bit g);
    ph  = h;
    pg  = g;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    q_vq.delete(); q_per.delete(); q_dir.delete();
    rst = 1'b0;
  endtask

  task automatic check_last(input string name, input int vq, input int per, input int dir);
    int k;
    k = q_vq.size() - 1;
    check({name, "_vq"},     q_vq[k],  vq);
    check({name, "_period"}, q_per[k], per);
    check({name, "_dir"},    q_dir[k], dir);
  endtask

  initial begin
    #1;
    do_reset(0, 0);
    check("reset_vq", bus.vq, 0);
    check("reset_dir", bus.dir, 1);
    check("reset_stopped", bus.stopped, 0);

    // pulseH 512/512
    for (int i = 0; i < 4; i++) begin hold(1, 0, 512); hold(0, 0, 512); end
    check("h512_count", q_vq.size(), 3);
    check_last("h512", 512, 1024, 1);
    check("h512_fault", bus.fault, 0);
    check("model_vq_h512", m_vq, 512);
    check("model_per_h512", m_per, 1024);

    // pulseG 1/1023
    do_reset(0, 0);
    for (int i = 0; i < 3; i++) begin hold(0, 1, 1); hold(0, 0, 1023); end
    check("g1_count", q_vq.size(), 2);
    check_last("g1", 1, 1024, 0);
    check("model_vq_g1", m_vq, 1);

    // constant low from reset: stopped exactly TIMEOUT+3 clocks after release
    do_reset(0, 0);
    hold(0, 0, TIMEOUT + 2);
    check("low_stopped_early", bus.stopped, 0);
    check("low_count_early", q_vq.size(), 0);
    hold(0, 0, 1);
    check("low_stopped", bus.stopped, 1);
    check("low_count", q_vq.size(), 1);
    check_last("low", 0, 0, 1);
    hold(0, 0, 100);
    check("low_single_valid", q_vq.size(), 1);

    // pulseH held high from reset: rise sampled on first edge
    do_reset(1, 0);
    hold(1, 0, TIMEOUT + 3);
    check("hold_stopped_early", bus.stopped, 0);
    hold(1, 0, 1);
    check("hold_stopped", bus.stopped, 1);
    check("hold_count", q_vq.size(), 1);
    check_last("hold", 1023, 0, 1);
    check("model_vq_hold", m_vq, 1023);
    hold(1, 0, 200);
    check("hold_single_valid", q_vq.size(), 1);
    hold(0, 0, 10);
    check("hold_stopped_clear", bus.stopped, 0);
    hold(1, 0, 100); hold(0, 0, 100);
    check("hold_no_valid_first_rise", q_vq.size(), 1);
    hold(1, 0, 10);
    check("hold_resume_count", q_vq.size(), 2);
    check_last("hold_resume", 100, 200, 1);

    // overlap fault, sticky until reset
    do_reset(0, 0);
    hold(1, 1, 1);
    hold(0, 0, 20);
    check("fault_set", bus.fault, 1);
    hold(0, 0, TIMEOUT + 100);
    check("fault_sticky", bus.fault, 1);
    check("fault_stopped", bus.stopped, 1);
    rst = 1'b1;
    #1;
    check("fault_async_clear", bus.fault, 0);

    // direction reversal
    do_reset(0, 0);
    for (int i = 0; i < 3; i++) begin hold(1, 0, 256); hold(0, 0, 768); end
    for (int i = 0; i < 2; i++) begin hold(0, 1, 768); hold(0, 0, 256); end
    check("rev_count", q_vq.size(), 4);
    check("rev_g1_vq", q_vq[2], 256);
    check("rev_g1_dir", q_dir[2], 1);
    check("rev_g2_vq", q_vq[3], 768);
    check("rev_g2_dir", q_dir[3], 0);
    check("rev_g2_period", q_per[3], 1024);
    check("rev_fault", bus.fault, 0);

    // reset in the middle of a HIGH phase
    do_reset(0, 0);
    for (int i = 0; i < 2; i++) begin hold(1, 0, 512); hold(0, 0, 512); end
    check("mid_pre_count", q_vq.size(), 1);
    hold(1, 0, 100);
    #2;
    rst = 1'b1;
    #1;
    check("mid_vq", bus.vq, 0);
    check("mid_period", bus.period, 0);
    check("mid_dir", bus.dir, 1);
    check("mid_valid", bus.valid, 0);
    check("mid_stopped", bus.stopped, 0);
    check("mid_fault", bus.fault, 0);
    repeat (2) @(negedge clk);
    #1;
    q_vq.delete(); q_per.delete(); q_dir.delete();
    rst = 1'b0;
    hold(1, 0, 200);
    hold(0, 0, 512);
    check("mid_no_valid", q_vq.size(), 0);
    hold(1, 0, 10);
    check("mid_count", q_vq.size(), 1);
    check_last("mid", 200, 712, 1);
    hold(0, 0, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_decode.md
PWM_DECODE -- requirements
Module: pwm_decode

Interface
REQ-001 The block SHALL have parameter CNT_W, default 10, giving the duty result width; the nominal PWM period is 2^CNT_W clocks.
REQ-002 The block SHALL have parameter TIMEOUT, default 2048, giving the number of clocks without an input edge before a stopped condition is declared; legal range 2..4095.
REQ-003 The block SHALL have these ports, one clock and one reset, with reset asynchronous and active-high:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- pulseH  in  1  forward PWM line, asynchronous to clk
- pulseG  in  1  reverse PWM line, asynchronous to clk
- vq  out  CNT_W  decoded duty (high-time clocks)
- period  out  12  measured period in clocks
- dir  out  1  1 = pulseH active, 0 = pulseG active
- valid  out  1  one-cycle strobe on each new vq/period
- stopped  out  1  no edge seen for TIMEOUT clocks
- fault  out  1  sticky flag: both lines were high together

Function
REQ-004 Each input SHALL pass through a 2-flop synchronizer; all logic SHALL use synchronized values sH and sG, with p = sH | sG.
REQ-005 A rise SHALL be detected when p is 1 and its registered previous value is 0; a fall is the converse.
REQ-006 The block SHALL use FSM states IDLE, HIGH and LOW.
REQ-007 In IDLE, a rise SHALL move to HIGH and load hi_cnt=1 and per_cnt=1, with no valid.
REQ-008 In HIGH, a fall SHALL move to LOW.
REQ-009 In LOW, a rise SHALL move to HIGH, assert valid, and reload hi_cnt=1 and per_cnt=1.
REQ-010 per_cnt (12 bits) SHALL increment every clock in HIGH and LOW and saturate at 4095.
REQ-011 hi_cnt (CNT_W+1 bits) SHALL increment every clock in which p=1 in HIGH and saturate at 2^(CNT_W+1)-1.
REQ-012 On the valid cycle the block SHALL latch period=per_cnt and vq=min(hi_cnt, 2^CNT_W-1).
REQ-013 dir SHALL be latched at the rise as sH, and SHALL update only at rises.
REQ-014 Latency: a raw input rise first sampled at clock edge k SHALL make valid high in the cycle following edge k+2.
REQ-015 Timeout counter:
- cleared on any rise or fall;
- otherwise increments, saturating at TIMEOUT.
REQ-016 When the timeout counter reaches TIMEOUT, the FSM SHALL enter IDLE, stopped SHALL be set, and valid SHALL pulse exactly once.
- vq SHALL be 2^CNT_W-1 if p=1, else 0.
- period SHALL be 0.
REQ-017 stopped SHALL clear on the next rise or fall.
REQ-018 While stopped is set, no further valid SHALL occur until the next measurement completes.
REQ-019 fault SHALL set in any cycle with sH=1 and sG=1, and SHALL clear only on rst; decoding SHALL continue, using p.
REQ-020 Direction reversal, where the active line changes between periods, SHALL be decoded as a normal rise and SHALL NOT set fault.
REQ-021 If a rise and a timeout coincide in one cycle, the rise SHALL take priority and no timeout valid SHALL occur.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 rst SHALL immediately force:
- FSM=IDLE;
- all counters and synchronizer flops=0;
- vq=0, period=0, dir=1, valid=0, stopped=0, fault=0.
REQ-024 After rst deassertion, the first rise SHALL NOT produce valid; the first valid SHALL come at the second rise.
REQ-025 rst asserted mid-period SHALL discard the partial measurement.
REQ-026 With rst deasserted and constant-low inputs, stopped SHALL set TIMEOUT+3 clocks after deassertion, with vq=0 and one valid pulse.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- pulseH 512 high / 512 low, repeated -> from the second rise, each valid gives vq=0x200, period=1024, dir=1, fault=0.
- pulseG 1 high / 1023 low -> vq=0x001, period=1024, dir=0.
- pulseH held high from reset -> TIMEOUT+3 clocks after the rise: stopped=1, vq=0x3FF, period=0, one valid pulse only.
- pulseH and pulseG high together for 1 clock -> fault=1, staying 1 until rst.
- pulseH 256/768 for 3 periods, then pulseG 768/256 -> on the first pulseG-started period valid gives vq=0x100, dir=1; on the next, vq=0x300, dir=0; fault=0.
- rst pulse mid-HIGH -> all outputs 0 at once (dir=1); the next valid comes only after two further rises.
